weight_ser_tx: RTL and testbench

- Serial transmitter for the trained weight vector; the opposite direction of the host-to-`main` serial load link.
- After SGD completes, captures the (feat+1) 16-bit weights in parallel and shifts them out on a single line, one bit per CLK.
- Uses the same framing as the load link: words ordered from highest feature index down to index 0, each word LSB first, no gaps.
- Sits inside `main`, between the weight register file and the external serial output pin.

---
 rtl/minor_pkg.sv | 24 ++
 rtl/piso_word.sv | 27 ++
 rtl/weight_ser_tx.sv | 123 ++++++++++++
 tb/tb_weight_ser_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/minor_pkg.sv
// Shared constants, state type and word helpers for the weight serial transmitter.
package minor_pkg;

  localparam int unsigned LENGTH       = 16;
  localparam int unsigned MAX_FEATURES = 15;
  localparam int unsigned FEAT_BITS    = 4;
  localparam int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} tx_state_t;

  typedef logic [LENGTH-1:0] word_t;

  function automatic word_t get_word(logic [DATA_WIDTH-1:0] data, logic [FEAT_BITS-1:0] idx);
    return word_t'(data >> (32'(idx) * LENGTH));
  endfunction

  function automatic logic [FEAT_BITS-1:0] clamp_feat(logic [FEAT_BITS-1:0] f);
    int unsigned fi;
    fi = 32'(f);
    if (fi > MAX_FEATURES) return FEAT_BITS'(MAX_FEATURES);
    return f;
  endfunction

endpackage

// File: rtl/piso_word.sv
// Parallel-load, right-shifting word register; the serial output is bit 0.
module piso_word
  import minor_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  shift,
  input  word_t din,
  output logic  dout
);

  word_t sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {1'b0, sr_q[LENGTH-1:1]};
    end
  end

  assign dout = sr_q[0];

endmodule

// File: rtl/weight_ser_tx.sv
// Serial weight transmitter: words from index feat down to 0, each LSB first, no gaps.
// Define WEIGHT_SER_TX_PARITY_EN to append an even-parity bit after every word.
module weight_ser_tx
  import minor_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [FEAT_BITS-1:0]  feat,
  input  logic [DATA_WIDTH-1:0] W,
  output logic                  Q,
  output logic                  Q_VALID,
  output logic                  BUSY,
  output logic                  DONE
);

`ifdef WEIGHT_SER_TX_PARITY_EN
  localparam int unsigned LastBit = LENGTH;
`else
  localparam int unsigned LastBit = LENGTH - 1;
`endif
  localparam int unsigned BitW = $clog2(LastBit + 1);

  tx_state_t             state_q;
  logic [DATA_WIDTH-1:0] shadow_q;
  logic [FEAT_BITS-1:0]  word_idx_q;
  logic [BitW-1:0]       bit_idx_q;
  logic [FEAT_BITS-1:0]  last_idx;
  logic                  word_end;
  logic                  piso_load;
  logic                  piso_shift;
  word_t                 piso_din;

  assign last_idx = clamp_feat(feat);
  assign word_end = (bit_idx_q == BitW'(LastBit));

  // The shifter is loaded one edge ahead so Q is a flop output with no added latency;
  // loading zero at frame end keeps Q low outside SHIFT.
  always_comb begin
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_din   = '0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          piso_load = 1'b1;
          piso_din  = get_word(W, last_idx);
        end
      end
      SHIFT: begin
        if (word_end) begin
          piso_load = 1'b1;
          if (word_idx_q != '0) piso_din = get_word(shadow_q, word_idx_q - 1'b1);
        end
`ifdef WEIGHT_SER_TX_PARITY_EN
        else if (bit_idx_q == BitW'(LENGTH - 1)) begin
          piso_load = 1'b1;
          piso_din  = word_t'(^get_word(shadow_q, word_idx_q));
        end
`endif
        else begin
          piso_shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      word_idx_q <= '0;
      bit_idx_q  <= '0;
      Q_VALID    <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START) begin
            shadow_q   <= W;
            word_idx_q <= last_idx;
            bit_idx_q  <= '0;
            Q_VALID    <= 1'b1;
            BUSY       <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (word_end) begin
            bit_idx_q <= '0;
            if (word_idx_q == '0) begin
              state_q <= FIN;
              Q_VALID <= 1'b0;
              DONE    <= 1'b1;
            end else begin
              word_idx_q <= word_idx_q - 1'b1;
            end
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          BUSY    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  piso_word u_piso (
    .clk   (CLK),
    .rst_n (RST),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (piso_din),
    .dout  (Q)
  );

endmodule

// File: tb/tb_weight_ser_tx.sv
// Self-checking bench for weight_ser_tx: queue-based frame model plus directed literal checks.
module tb_weight_ser_tx;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic [3:0]   feat = '0;
  logic [255:0] W = '0;
  logic         Q, Q_VALID, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  weight_ser_tx dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .feat    (feat),
    .W       (W),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: expected bit stream as a queue, phases idle / sending / done-cycle.
  bit m_bits[$];
  int m_phase = 0;
  bit exp_q = 0, exp_v = 0, exp_busy = 0, exp_done = 0;

  task automatic model_build(input logic [3:0] f, input logic [255:0] w);
    int last;
    logic [15:0] wd;
    last = (int'(f) > 15) ? 15 : int'(f);
    for (int k = last; k >= 0; k--) begin
      wd = w[k*16 +: 16];
      for (int b = 0; b < 16; b++) m_bits.push_back(wd[b]);
`ifdef WEIGHT_SER_TX_PARITY_EN
      m_bits.push_back(^wd);
`endif
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      m_bits.delete();
      m_phase = 0;
      exp_q = 0; exp_v = 0; exp_busy = 0; exp_done = 0;
    end else begin
      exp_done = 0;
      if (m_phase == 2) begin
        m_phase = 0;
        exp_busy = 0;
      end else if (m_phase == 1) begin
        if (m_bits.size() > 0) begin
          exp_q = m_bits.pop_front();
          exp_v = 1;
        end else begin
          m_phase = 2; exp_q = 0; exp_v = 0; exp_done = 1;
        end
      end else if (START) begin
        model_build(feat, W);
        m_phase = 1;
        exp_busy = 1;
        exp_q = m_bits.pop_front();
        exp_v = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge CLK);
    chk("cycle{Q,VALID,BUSY,DONE}", 64'({Q, Q_VALID, BUSY, DONE}),
        64'({exp_q, exp_v, exp_busy, exp_done}));
  end

  // Monitor: deserialise valid bits, time DONE relative to START.
  int cyc = 0;
  int start_cyc = 0;
  bit rx[$];
  int busy_cnt = 0, done_cnt = 0, done_cyc = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  initial forever begin
    @(negedge CLK);
    if (Q_VALID) rx.push_back(Q);
    if (BUSY) busy_cnt++;
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc - start_cyc;
    end
  end

  function automatic logic [63:0] pack_rx(int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < rx.size(); i++) v[i] = rx[i];
    return v;
  endfunction

  function automatic logic [15:0] rx_word(int j);
    logic [15:0] v;
    v = '0;
    for (int b = 0; b < 16; b++) if (j*16 + b < rx.size()) v[b] = rx[j*16 + b];
    return v;
  endfunction

  task automatic start_frame(input logic [3:0] f, input logic [255:0] w);
    @(negedge CLK);
    rx.delete(); busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    start_cyc = cyc;
    START = 1'b1; feat = f; W = w;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!DONE && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!DONE) begin
      errors++;
      $display("FAIL done_timeout: no DONE within %0d cycles", budget);
    end
    #1;
  endtask

  logic [255:0] wv;

  initial begin
    // Reset
    repeat (10) @(negedge CLK);
    chk("reset_outputs", 64'({Q, Q_VALID, BUSY, DONE}), 64'h0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Two-word frame
    wv = '0; wv[15:0] = 16'h0001; wv[31:16] = 16'h8000;
    start_frame(4'd1, wv);
    wait_done(60);
    chk("t1_bits", pack_rx(32), 64'h0000_0000_0001_8000);
    chk("t1_len", 64'(rx.size()), 64'd32);
    chk("t1_done_cycle", 64'(done_cyc), 64'd33);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd33);
    repeat (3) @(negedge CLK);

    // Full-size frame, unused words poisoned
    for (int k = 0; k < 16; k++) wv[k*16 +: 16] = (k <= 11) ? 16'hA500 + 16'(k) : 16'hDEAD;
    start_frame(4'd11, wv);
    wait_done(300);
    chk("t2_len", 64'(rx.size()), 64'd192);
    chk("t2_done_cycle", 64'(done_cyc), 64'd193);
    for (int j = 0; j < 12; j++) chk("t2_word", 64'(rx_word(j)), 64'(16'hA500 + 16'(11 - j)));
    repeat (3) @(negedge CLK);

    // Single word, restart attempt and bus change mid-frame
    chk("t3_idle_before", 64'({Q, Q_VALID}), 64'h0);
    wv = '0; wv[15:0] = 16'hFFFF;
    start_frame(4'd0, wv);
    repeat (5) @(negedge CLK);
    START = 1'b1; feat = 4'd3; W = '0;
    @(negedge CLK);
    START = 1'b0;
    wait_done(40);
    chk("t3_bits", pack_rx(16), 64'hFFFF);
    chk("t3_len", 64'(rx.size()), 64'd16);
    chk("t3_done_cycle", 64'(done_cyc), 64'd17);
    // START during the DONE cycle must be ignored
    START = 1'b1; feat = 4'd0; W = 256'h5555;
    @(negedge CLK);
    START = 1'b0;
    chk("t3_fin_start_ignored", 64'({BUSY, Q_VALID, Q}), 64'h0);
    wv = '0; wv[15:0] = 16'h1234;
    start_frame(4'd0, wv);
    wait_done(40);
    chk("t3_restart_bits", pack_rx(16), 64'h1234);
    chk("t3_restart_done", 64'(done_cyc), 64'd17);
    repeat (3) @(negedge CLK);

    // Reset mid-frame
    for (int k = 0; k < 16; k++) wv[k*16 +: 16] = 16'hA500 + 16'(k);
    start_frame(4'd11, wv);
    for (int n = 0; n < 100 && rx.size() < 40; n++) @(negedge CLK);
    chk("t4_reached_bit40", 64'(rx.size() >= 40), 64'd1);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1 chk("t4_async_reset", 64'({Q, Q_VALID, BUSY, DONE}), 64'h0);
    repeat (3) @(negedge CLK);
    chk("t4_no_done", 64'(done_cnt), 64'd0);
    RST = 1'b1;
    for (int k = 0; k < 16; k++) wv[k*16 +: 16] = 16'h1111 * 16'(k + 1);
    start_frame(4'd2, wv);
    wait_done(80);
    chk("t4_w2", 64'(rx_word(0)), 64'h3333);
    chk("t4_w1", 64'(rx_word(1)), 64'h2222);
    chk("t4_w0", 64'(rx_word(2)), 64'h1111);
    chk("t4_done_cycle", 64'(done_cyc), 64'd49);
    repeat (3) @(negedge CLK);

`ifdef WEIGHT_SER_TX_PARITY_EN
    wv = '0; wv[15:0] = 16'h0007; wv[31:16] = 16'h0003;
    start_frame(4'd1, wv);
    wait_done(60);
    chk("t5_len", 64'(rx.size()), 64'd34);
    chk("t5_bits", pack_rx(34), 64'h2_000E_0003);
    chk("t5_done_cycle", 64'(done_cyc), 64'd35);
    repeat (3) @(negedge CLK);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
